// File: rtl/output_channel_scan_sel.sv
// Registered N-channel output selector with manual select, auto-scan rotation,
// freeze/hold and a one-cycle update strobe for downstream display/UART logic.
module output_channel_scan_sel #(
    parameter int  WIDTH    = 4,
    parameter int  NCH      = 3,
    parameter int  SCAN_DIV = 100,
    localparam int SELW     = $clog2(NCH + 1)
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic [NCH*WIDTH-1:0]   ch_data,
    input  logic [SELW-1:0]        select,
    input  logic                   mode,
    input  logic                   freeze,
    output logic [WIDTH-1:0]       out,
    output logic [SELW-1:0]        out_ch,
    output logic                   upd
);

    localparam int CW = $clog2(SCAN_DIV);

    typedef enum logic {
        MANUAL = 1'b0,
        SCAN   = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic              mode_q;
    logic              mode_q_nx;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_nx;
    logic [SELW-1:0]   ch_nx;
    logic [WIDTH-1:0]  out_nx;
    logic              upd_nx;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state  <= MANUAL;
            mode_q <= 1'b0;
            cnt    <= '0;
            out    <= '0;
            out_ch <= '0;
            upd    <= 1'b0;
        end else begin
            state  <= state_nx;
            mode_q <= mode_q_nx;
            cnt    <= cnt_nx;
            out    <= out_nx;
            out_ch <= ch_nx;
            upd    <= upd_nx;
        end
    end

    // Freeze keeps every register as-is; a mode edge seen during freeze is
    // still pending against the held mode_q and fires entry on release.
    always_comb begin
        state_nx  = state;
        mode_q_nx = mode_q;
        cnt_nx    = cnt;
        ch_nx     = out_ch;
        out_nx    = out;
        upd_nx    = 1'b0;

        if (!freeze) begin
            mode_q_nx = mode;
            if (!mode) begin
                state_nx = MANUAL;
                cnt_nx   = '0;
                if (select != '0 && select <= SELW'(NCH)) begin
                    ch_nx = select;
                end else begin
                    ch_nx = '0;
                end
            end else begin
                state_nx = SCAN;
                if (!mode_q || state == MANUAL) begin
                    ch_nx  = SELW'(1);
                    cnt_nx = '0;
                end else if (cnt == CW'(SCAN_DIV - 1)) begin
                    cnt_nx = '0;
                    if (out_ch == SELW'(NCH)) begin
                        ch_nx = SELW'(1);
                    end else begin
                        ch_nx = out_ch + SELW'(1);
                    end
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end

            // Live data of the chosen channel, not a snapshot taken on entry.
            out_nx = '0;
            for (int k = 1; k <= NCH; k++) begin
                if (ch_nx == SELW'(k)) begin
                    out_nx = ch_data[k*WIDTH-1 -: WIDTH];
                end
            end

            upd_nx = (out_nx != out) || (ch_nx != out_ch);
        end
    end

endmodule

// File: tb/tb_output_channel_scan_sel.sv
// Randomized scoreboard bench for output_channel_scan_sel against a dwell-time
// reference model, plus directed checks on a 5-channel instance.
module tb_output_channel_scan_sel;

    localparam int W  = 4;
    localparam int N  = 3;
    localparam int SD = 4;
    localparam int SW = $clog2(N + 1);
    localparam int N5 = 5;
    localparam int SW5 = $clog2(N5 + 1);

    logic              clk = 1'b0;
    logic              n_rst = 1'b1;
    logic [N*W-1:0]    ch_data;
    logic [SW-1:0]     select;
    logic              mode;
    logic              freeze;
    logic [W-1:0]      out;
    logic [SW-1:0]     out_ch;
    logic              upd;

    logic              n_rst5 = 1'b0;
    logic [N5*W-1:0]   ch_data5;
    logic [SW5-1:0]    select5;
    logic              mode5;
    logic              freeze5;
    logic [W-1:0]      out5;
    logic [SW5-1:0]    out_ch5;
    logic              upd5;

    output_channel_scan_sel #(.WIDTH(W), .NCH(N), .SCAN_DIV(SD)) dut (
        .clk(clk), .n_rst(n_rst), .ch_data(ch_data), .select(select),
        .mode(mode), .freeze(freeze), .out(out), .out_ch(out_ch), .upd(upd)
    );

    output_channel_scan_sel #(.WIDTH(W), .NCH(N5), .SCAN_DIV(SD)) dut5 (
        .clk(clk), .n_rst(n_rst5), .ch_data(ch_data5), .select(select5),
        .mode(mode5), .freeze(freeze5), .out(out5), .out_ch(out_ch5), .upd(upd5)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0]  o;
        logic [SW-1:0] c;
        logic          u;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: shown channel follows from cycles elapsed since scan entry.
    int            ticks = 0;
    bit            m_mq = 1'b0;
    logic [W-1:0]  m_out = '0;
    logic [SW-1:0] m_ch = '0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [W-1:0] chan(input logic [N*W-1:0] d, input int k);
        logic [W-1:0] v;
        v = '0;
        if (k >= 1 && k <= N) v = d[k*W-1 -: W];
        return v;
    endfunction

    task automatic applyStimulus(input bit m, input logic [SW-1:0] s, input bit f,
                                 input logic [N*W-1:0] d);
        int           nch;
        logic [W-1:0] nout;
        exp_t         e;
        @(negedge clk);
        mode    = m;
        select  = s;
        freeze  = f;
        ch_data = d;
        e.u = 1'b0;
        if (!f) begin
            if (m) begin
                if (!m_mq) ticks = 0;
                else ticks++;
                nch = (ticks / SD) % N + 1;
            end else begin
                nch = (int'(s) >= 1 && int'(s) <= N) ? int'(s) : 0;
            end
            m_mq = m;
            nout = chan(d, nch);
            e.u  = (nout != m_out) || (SW'(nch) != m_ch);
            m_out = nout;
            m_ch  = SW'(nch);
        end
        e.o = m_out;
        e.c = m_ch;
        exp_q.push_back(e);
    endtask

    // Reset asserted mid-cycle after the scoreboard has drained.
    task automatic doReset();
        @(posedge clk);
        #2;
        n_rst = 1'b0;
        #1;
        checkOutput("rst_out", 32'(out), 32'h0);
        checkOutput("rst_out_ch", 32'(out_ch), 32'h0);
        checkOutput("rst_upd", 32'(upd), 32'h0);
        @(posedge clk);
        #1;
        checkOutput("rst_hold_out_ch", 32'(out_ch), 32'h0);
        #1;
        n_rst = 1'b1;
        m_mq  = 1'b0;
        m_out = '0;
        m_ch  = '0;
        ticks = 0;
    endtask

    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("out", 32'(out), 32'(e.o));
            checkOutput("out_ch", 32'(out_ch), 32'(e.c));
            checkOutput("upd", 32'(upd), 32'(e.u));
        end
    end

    initial begin
        logic [N*W-1:0] d;
        logic [N*W-1:0] da;
        bit             m;
        d  = {4'h9, 4'h5, 4'h3};
        da = {4'h9, 4'hA, 4'h3};
        ch_data = d;
        select  = '0;
        mode    = 1'b0;
        freeze  = 1'b0;
        ch_data5 = {4'h1, 4'h7, 4'h9, 4'h5, 4'h3};
        select5  = '0;
        mode5    = 1'b0;
        freeze5  = 1'b0;

        #3;
        n_rst = 1'b0;
        #1;
        checkOutput("init_rst_out", 32'(out), 32'h0);
        checkOutput("init_rst_out_ch", 32'(out_ch), 32'h0);
        checkOutput("init_rst_upd", 32'(upd), 32'h0);
        @(posedge clk);
        #2;
        n_rst = 1'b1;

        applyStimulus(1'b0, 2'd2, 1'b0, d);
        applyStimulus(1'b0, 2'd2, 1'b0, d);
        applyStimulus(1'b0, 2'd0, 1'b0, d);
        applyStimulus(1'b0, 2'd0, 1'b0, d);

        for (int i = 0; i < 17; i++) applyStimulus(1'b1, 2'd0, 1'b0, d);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 2'd0, 1'b0, da);
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, SW'($urandom_range(0, 3)), 1'b1, da);
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 2'd0, 1'b0, da);

        doReset();
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 2'd0, 1'b0, d);

        m = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) m = ~m;
            if ($urandom_range(0, 3) == 0) d = N*W'($urandom);
            if ($urandom_range(0, 199) == 0) doReset();
            applyStimulus(m, SW'($urandom_range(0, 3)), $urandom_range(0, 7) == 0, d);
        end

        @(posedge clk);
        #2;
        checkOutput("queue_drained", 32'(exp_q.size()), 32'h0);

        @(negedge clk);
        n_rst5  = 1'b1;
        select5 = 3'd4;
        @(posedge clk);
        #1;
        checkOutput("n5_sel4_out", 32'(out5), 32'h7);
        checkOutput("n5_sel4_out_ch", 32'(out_ch5), 32'd4);
        @(negedge clk);
        select5 = 3'd7;
        @(posedge clk);
        #1;
        checkOutput("n5_sel7_out", 32'(out5), 32'h0);
        checkOutput("n5_sel7_out_ch", 32'(out_ch5), 32'd0);
        checkOutput("n5_sel7_upd", 32'(upd5), 32'd1);
        @(negedge clk);
        mode5 = 1'b1;
        for (int i = 0; i < 9; i++) @(posedge clk);
        #1;
        checkOutput("n5_scan_ch3", 32'(out_ch5), 32'd3);
        checkOutput("n5_scan_out", 32'(out5), 32'h9);
        #2;
        n_rst5 = 1'b0;
        #1;
        checkOutput("n5_rst_out", 32'(out5), 32'h0);
        checkOutput("n5_rst_out_ch", 32'(out_ch5), 32'd0);
        @(posedge clk);
        #2;
        n_rst5 = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("n5_restart_ch", 32'(out_ch5), 32'd1);
        checkOutput("n5_restart_out", 32'(out5), 32'h3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
